// File: rtl/video_pattern_gen.sv
// video_pattern_gen: raster timing generator with LFSR, ramp, colour-bar and solid-colour patterns.
module video_pattern_gen #(
    parameter int          COLORDEPTH = 8,
    parameter int          H_ACTIVE   = 640,
    parameter int          H_FP       = 16,
    parameter int          H_SYNC     = 96,
    parameter int          H_BP       = 48,
    parameter int          V_ACTIVE   = 480,
    parameter int          V_FP       = 10,
    parameter int          V_SYNC     = 2,
    parameter int          V_BP       = 33,
    parameter bit          HS_POL     = 1'b0,
    parameter bit          VS_POL     = 1'b0,
    parameter logic [23:0] LFSR_SEED  = 24'had98b7,
    parameter bit          RESEED     = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en_i,
    input  logic [1:0]              mode_i,
    input  logic [3*COLORDEPTH-1:0] solid_i,
    output logic [COLORDEPTH-1:0]   red_o,
    output logic [COLORDEPTH-1:0]   green_o,
    output logic [COLORDEPTH-1:0]   blue_o,
    output logic                    dv_o,
    output logic                    hs_o,
    output logic                    vs_o,
    output logic                    sof_o,
    output logic [15:0]             frame_cnt_o
);
    localparam int CD = COLORDEPTH;
    localparam logic [15:0] HT  = 16'(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam logic [15:0] VT  = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam logic [15:0] HA  = 16'(H_ACTIVE);
    localparam logic [15:0] VA  = 16'(V_ACTIVE);
    localparam logic [15:0] HS0 = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0] HS1 = 16'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [15:0] VS0 = 16'(V_ACTIVE + V_FP);
    localparam logic [15:0] VS1 = 16'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [15:0] BW  = 16'((H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1);

    logic [15:0]     h_cnt, v_cnt, frame_cnt, hdiv;
    logic [23:0]     lfsr, lfsr_c, lfsr_n;
    logic [1:0]      mode_q, mode_c;
    logic [3*CD-1:0] solid_q, solid_c, rgb_c;
    logic [2:0]      bar;
    logic            origin, active, h_last, v_last, hs_c, vs_c;

    // The frame-origin pixel already uses the newly latched settings and the reseeded LFSR.
    always_comb begin
        origin  = h_cnt == 16'd0 && v_cnt == 16'd0;
        active  = h_cnt < HA && v_cnt < VA;
        h_last  = h_cnt == HT - 16'd1;
        v_last  = v_cnt == VT - 16'd1;
        mode_c  = origin ? mode_i : mode_q;
        solid_c = origin ? solid_i : solid_q;
        lfsr_c  = (origin && RESEED) ? LFSR_SEED : lfsr;
        lfsr_n  = {lfsr_c[22:0], lfsr_c[3] ^ lfsr_c[8] ^ lfsr_c[13] ^ lfsr_c[22]};
        hdiv    = h_cnt / BW;
        bar     = (hdiv > 16'd7) ? 3'd7 : hdiv[2:0];
        rgb_c   = (mode_c == 2'd0) ? {lfsr_c[23 -: CD], lfsr_c[15 -: CD], lfsr_c[7 -: CD]} :
                  (mode_c == 2'd1) ? {h_cnt[CD-1:0], v_cnt[CD-1:0], frame_cnt[CD-1:0]} :
                  (mode_c == 2'd2) ? {{CD{~bar[2]}}, {CD{~bar[1]}}, {CD{~bar[0]}}} : solid_c;
        hs_c    = (h_cnt >= HS0 && h_cnt < HS1) ? HS_POL : ~HS_POL;
        vs_c    = (v_cnt >= VS0 && v_cnt < VS1) ? VS_POL : ~VS_POL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt   <= '0;
            v_cnt   <= '0;
            frame_cnt <= '0;
            lfsr    <= LFSR_SEED;
            mode_q  <= 2'd0;
            solid_q <= '0;
            {red_o, green_o, blue_o} <= '0;
            dv_o    <= 1'b0;
            sof_o   <= 1'b0;
            hs_o    <= ~HS_POL;
            vs_o    <= ~VS_POL;
        end else if (en_i) begin
            h_cnt   <= h_last ? 16'd0 : h_cnt + 16'd1;
            v_cnt   <= h_last ? (v_last ? 16'd0 : v_cnt + 16'd1) : v_cnt;
            frame_cnt <= frame_cnt + 16'(h_last && v_last);
            lfsr    <= active ? lfsr_n : lfsr_c;
            mode_q  <= mode_c;
            solid_q <= solid_c;
            {red_o, green_o, blue_o} <= active ? rgb_c : '0;
            dv_o    <= active;
            sof_o   <= origin;
            hs_o    <= hs_c;
            vs_o    <= vs_c;
        end else begin
            {red_o, green_o, blue_o} <= '0;
            dv_o    <= 1'b0;
            sof_o   <= 1'b0;
        end
    end

    assign frame_cnt_o = frame_cnt;
endmodule

// File: tb/tb_video_pattern_gen.sv
// tb_video_pattern_gen: directed tests on a 16x8 raster (8x4 active).
module tb_video_pattern_gen;
    logic        clk = 1'b0, rst = 1'b1, en = 1'b0;
    logic [1:0]  mode_i = 2'd0;
    logic [23:0] solid_i = '0;
    logic [7:0]  red, green, blue;
    logic        dv, hs, vs, sof;
    logic [15:0] fc;
    logic [23:0] rgb;
    int          total = 0, bad = 0;

    localparam logic [23:0] SEED = 24'had98b7;

    video_pattern_gen #(
        .COLORDEPTH(8), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .LFSR_SEED(SEED), .RESEED(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .en_i(en), .mode_i(mode_i), .solid_i(solid_i),
        .red_o(red), .green_o(green), .blue_o(blue), .dv_o(dv),
        .hs_o(hs), .vs_o(vs), .sof_o(sof), .frame_cnt_o(fc)
    );

    assign rgb = {red, green, blue};
    always #5 clk = ~clk;

    function automatic logic [23:0] step(input logic [23:0] x);
        return {x[22:0], x[3] ^ x[8] ^ x[13] ^ x[22]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench with the frame-origin pixel on the outputs.
    task automatic do_reset(input logic [1:0] m);
        en = 1'b1; mode_i = m; rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        en = 1'b1; rst = 1'b1;
        tick(); tick();
        total += 6;
        if (dv !== 1'b0)  begin bad++; $display("FAIL reset_dv got=%b exp=0", dv); end
        if (sof !== 1'b0) begin bad++; $display("FAIL reset_sof got=%b exp=0", sof); end
        if (hs !== 1'b1)  begin bad++; $display("FAIL reset_hs got=%b exp=1", hs); end
        if (vs !== 1'b1)  begin bad++; $display("FAIL reset_vs got=%b exp=1", vs); end
        if (rgb !== 24'h0) begin bad++; $display("FAIL reset_rgb got=%h exp=0", rgb); end
        if (fc !== 16'h0) begin bad++; $display("FAIL reset_fc got=%h exp=0", fc); end
    endtask

    task automatic test_timing();
        int h, v;
        logic act;
        do_reset(2'd1);
        for (int k = 0; k < 128; k++) begin
            h = k % 16; v = k / 16; act = h < 8 && v < 4;
            total += 5;
            if (dv !== act) begin bad++; $display("FAIL tim_dv k=%0d got=%b exp=%b", k, dv, act); end
            if (sof !== (k == 0)) begin bad++; $display("FAIL tim_sof k=%0d got=%b", k, sof); end
            if (hs !== !(h >= 10 && h < 13)) begin bad++; $display("FAIL tim_hs k=%0d got=%b", k, hs); end
            if (vs !== !(v >= 5 && v < 7)) begin bad++; $display("FAIL tim_vs k=%0d got=%b", k, vs); end
            if (rgb !== (act ? {8'(h), 8'(v), 8'h00} : 24'h0))
                begin bad++; $display("FAIL tim_rgb k=%0d got=%h", k, rgb); end
            tick();
        end
        total += 3;
        if (sof !== 1'b1) begin bad++; $display("FAIL tim_sof2 got=%b exp=1", sof); end
        if (fc !== 16'd1) begin bad++; $display("FAIL tim_fc got=%0d exp=1", fc); end
        if (rgb !== 24'h000001) begin bad++; $display("FAIL tim_rgb2 got=%h exp=000001", rgb); end
    endtask

    task automatic test_lfsr();
        logic [23:0] m, f1[32];
        int idx;
        do_reset(2'd0);
        m = SEED; idx = 0;
        for (int k = 0; k < 128; k++) begin
            if (k % 16 < 8 && k / 16 < 4) begin
                total++;
                if (rgb !== m) begin bad++; $display("FAIL lfsr_f1 px=%0d got=%h exp=%h", idx, rgb, m); end
                f1[idx] = rgb; idx++; m = step(m);
            end
            tick();
        end
        idx = 0;
        for (int k = 0; k < 128; k++) begin
            if (k % 16 < 8 && k / 16 < 4) begin
                total++;
                if (rgb !== f1[idx]) begin bad++; $display("FAIL lfsr_f2 px=%0d got=%h exp=%h", idx, rgb, f1[idx]); end
                idx++;
            end
            tick();
        end
    endtask

    task automatic test_bars();
        logic [23:0] exp_bar[8] = '{24'hffffff, 24'hffff00, 24'hff00ff, 24'hff0000,
                                    24'h00ffff, 24'h00ff00, 24'h0000ff, 24'h000000};
        do_reset(2'd2);
        for (int l = 0; l < 2; l++) begin
            for (int k = 0; k < 16; k++) begin
                total++;
                if (rgb !== (k < 8 ? exp_bar[k] : 24'h0))
                    begin bad++; $display("FAIL bars l=%0d h=%0d got=%h", l, k, rgb); end
                tick();
            end
        end
    endtask

    task automatic test_mode_switch();
        int h, v;
        logic act;
        solid_i = 24'h0;
        do_reset(2'd1);
        for (int k = 0; k < 128; k++) begin
            h = k % 16; v = k / 16; act = h < 8 && v < 4;
            total++;
            if (rgb !== (act ? {8'(h), 8'(v), 8'h00} : 24'h0))
                begin bad++; $display("FAIL sw_ramp k=%0d got=%h", k, rgb); end
            if (k == 20) begin mode_i = 2'd3; solid_i = 24'h123456; end
            tick();
        end
        total++;
        if (fc !== 16'd1) begin bad++; $display("FAIL sw_fc got=%0d exp=1", fc); end
        for (int k = 0; k < 128; k++) begin
            act = k % 16 < 8 && k / 16 < 4;
            total++;
            if (rgb !== (act ? 24'h123456 : 24'h0))
                begin bad++; $display("FAIL sw_solid k=%0d got=%h", k, rgb); end
            if (k == 40) begin mode_i = 2'd2; solid_i = 24'habcdef; end
            tick();
        end
    endtask

    task automatic test_pause();
        do_reset(2'd1);
        tick(); tick();
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            total += 4;
            if (dv !== 1'b0) begin bad++; $display("FAIL pause_dv i=%0d got=%b", i, dv); end
            if (rgb !== 24'h0) begin bad++; $display("FAIL pause_rgb i=%0d got=%h", i, rgb); end
            if (hs !== 1'b1) begin bad++; $display("FAIL pause_hs i=%0d got=%b", i, hs); end
            if (vs !== 1'b1) begin bad++; $display("FAIL pause_vs i=%0d got=%b", i, vs); end
        end
        en = 1'b1;
        tick();
        total += 2;
        if (rgb !== 24'h030000) begin bad++; $display("FAIL pause_resume got=%h exp=030000", rgb); end
        if (dv !== 1'b1) begin bad++; $display("FAIL pause_resume_dv got=%b", dv); end
        for (int i = 0; i < 7; i++) tick();
        total++;
        if (hs !== 1'b0) begin bad++; $display("FAIL pause_hs_on got=%b exp=0", hs); end
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (hs !== 1'b0) begin bad++; $display("FAIL pause_hs_hold i=%0d got=%b exp=0", i, hs); end
        end
        en = 1'b1;
        tick(); tick();
        total++;
        if (hs !== 1'b0) begin bad++; $display("FAIL pause_hs12 got=%b exp=0", hs); end
        tick();
        total++;
        if (hs !== 1'b1) begin bad++; $display("FAIL pause_hs13 got=%b exp=1", hs); end
        tick(); tick(); tick();
        total += 2;
        if (rgb !== 24'h000100) begin bad++; $display("FAIL pause_line1 got=%h exp=000100", rgb); end
        if (dv !== 1'b1) begin bad++; $display("FAIL pause_line1_dv got=%b", dv); end
    endtask

    task automatic test_reset_mid();
        do_reset(2'd2);
        for (int i = 0; i < 148; i++) tick();
        total += 2;
        if (fc !== 16'd1) begin bad++; $display("FAIL rmid_fc_pre got=%0d exp=1", fc); end
        if (rgb !== 24'h00ffff) begin bad++; $display("FAIL rmid_bar got=%h exp=00ffff", rgb); end
        mode_i = 2'd0; rst = 1'b1;
        tick();
        total += 5;
        if (dv !== 1'b0) begin bad++; $display("FAIL rmid_dv got=%b exp=0", dv); end
        if (rgb !== 24'h0) begin bad++; $display("FAIL rmid_rgb got=%h exp=0", rgb); end
        if (fc !== 16'd0) begin bad++; $display("FAIL rmid_fc got=%0d exp=0", fc); end
        if (hs !== 1'b1) begin bad++; $display("FAIL rmid_hs got=%b exp=1", hs); end
        if (vs !== 1'b1) begin bad++; $display("FAIL rmid_vs got=%b exp=1", vs); end
        rst = 1'b0;
        tick();
        total += 3;
        if (sof !== 1'b1) begin bad++; $display("FAIL rmid_sof got=%b exp=1", sof); end
        if (dv !== 1'b1) begin bad++; $display("FAIL rmid_dv1 got=%b exp=1", dv); end
        if (rgb !== SEED) begin bad++; $display("FAIL rmid_seed got=%h exp=%h", rgb, SEED); end
        tick();
        total++;
        if (rgb !== step(SEED)) begin bad++; $display("FAIL rmid_px1 got=%h exp=%h", rgb, step(SEED)); end
    endtask

    initial begin
        test_reset();
        test_timing();
        test_lfsr();
        test_bars();
        test_mode_switch();
        test_pause();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
